// File: rtl/vga_sig_gen_if.sv
// Frame-buffer read port, board VGA pins and colour configuration for vga_sig_gen.
// master = the timing generator, slave = the environment (frame buffer + connector).
interface vga_sig_gen_if;
    logic [15:0] CONFIG_COLOURS;
    logic        VGA_DATA;
    logic [16:0] VGA_ADDR;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [7:0]  VGA_COLOUR;
    logic        FRAME_START;

    modport master (
        input  CONFIG_COLOURS, VGA_DATA,
        output VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_START
    );

    modport slave (
        output CONFIG_COLOURS, VGA_DATA,
        input  VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_START
    );
endinterface

// File: rtl/vga_sig_gen.sv
// 640x480 VGA timing generator reading a pixel-doubled 320x240 1-bpp frame buffer.
// Address is issued from the post-update counters; sync/colour come out one pixel later.
module vga_sig_gen #(
    parameter int CLK_DIV = 4,
    parameter int HTS     = 800,
    parameter int HPW     = 96,
    parameter int HBP     = 48,
    parameter int HDISP   = 640,
    parameter int VTS     = 521,
    parameter int VPW     = 2,
    parameter int VBP     = 29,
    parameter int VDISP   = 480
) (
    input  logic          CLK,
    input  logic          RESET,
    vga_sig_gen_if.master bus
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HTS + 1);
    localparam int VW = $clog2(VTS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HTS - 1);
    localparam logic [HW-1:0] H_PW     = HW'(HPW);
    localparam logic [HW-1:0] H_ST     = HW'(HPW + HBP);
    localparam logic [HW-1:0] H_END    = HW'(HPW + HBP + HDISP);
    localparam logic [VW-1:0] V_LAST   = VW'(VTS - 1);
    localparam logic [VW-1:0] V_PW     = VW'(VPW);
    localparam logic [VW-1:0] V_ST     = VW'(VPW + VBP);
    localparam logic [VW-1:0] V_END    = VW'(VPW + VBP + VDISP);

    // ST_WAIT holds the counters at 0 so the first tick after reset lands on pixel (0,0).
    typedef enum logic {ST_WAIT, ST_RUN} state_t;
    state_t r_state, w_state_nx;

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h, w_h_nx;
    logic [VW-1:0] r_v, w_v_nx;
    logic [16:0]   r_addr;
    logic          r_disp, r_hs, r_vs, r_fs;
    logic [7:0]    r_colour, r_fg, r_bg;

    logic          w_tick, w_run, w_disp_nx, w_frame;
    logic [8:0]    w_xh;
    logic [7:0]    w_yh;

    assign w_tick = (r_div == DIV_LAST);
    assign w_run  = (r_state == ST_RUN);

    always_comb begin
        w_state_nx = r_state;
        w_h_nx     = r_h;
        w_v_nx     = r_v;
        if (w_tick) begin
            w_state_nx = ST_RUN;
            if (r_state == ST_WAIT) begin
                w_h_nx = '0;
                w_v_nx = '0;
            end else if (r_h == H_LAST) begin
                w_h_nx = '0;
                w_v_nx = (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_h_nx = r_h + 1'b1;
            end
        end
    end

    assign w_disp_nx = (w_h_nx >= H_ST) && (w_h_nx < H_END) &&
                       (w_v_nx >= V_ST) && (w_v_nx < V_END);
    assign w_frame   = w_tick && (w_h_nx == '0) && (w_v_nx == '0);
    // Halved in-frame coordinates; only meaningful when w_disp_nx is set.
    assign w_xh      = 9'((w_h_nx - H_ST) >> 1);
    assign w_yh      = 8'((w_v_nx - V_ST) >> 1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_WAIT;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_addr   <= '0;
            r_disp   <= 1'b0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_colour <= '0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_fs     <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            r_fs  <= w_frame;
            if (w_tick) begin
                r_h    <= w_h_nx;
                r_v    <= w_v_nx;
                r_addr <= w_disp_nx ? {w_yh, w_xh} : 17'd0;
                r_disp <= w_disp_nx;
                // Delay stage: describes the pixel whose address went out on the previous tick.
                r_hs     <= w_run ? (r_h >= H_PW) : 1'b1;
                r_vs     <= w_run ? (r_v >= V_PW) : 1'b1;
                r_colour <= (w_run && r_disp) ? (bus.VGA_DATA ? r_fg : r_bg) : 8'h00;
                if (w_frame) begin
                    r_fg <= bus.CONFIG_COLOURS[15:8];
                    r_bg <= bus.CONFIG_COLOURS[7:0];
                end
            end
        end
    end

    assign bus.VGA_ADDR    = r_addr;
    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_COLOUR  = r_colour;
    assign bus.FRAME_START = r_fs;
endmodule

// File: tb/tb_vga_sig_gen.sv
// Directed checks of vga_sig_gen: inst A (CLK_DIV=2) for address/colour/frame behaviour,
// inst B (CLK_DIV=4) for sync pulse widths; both use a 10-line frame to keep runs short.
module tb_vga_sig_gen;
    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    int   fs_cnt_a = 0;

    vga_sig_gen_if bus_a ();
    vga_sig_gen_if bus_b ();

    vga_sig_gen #(.CLK_DIV(2), .VPW(2), .VBP(3), .VDISP(4), .VTS(10)) u_a (
        .CLK(CLK), .RESET(RESET), .bus(bus_a));
    vga_sig_gen #(.CLK_DIV(4), .VPW(2), .VBP(3), .VDISP(4), .VTS(10)) u_b (
        .CLK(CLK), .RESET(RESET), .bus(bus_b));

    always #5 CLK = ~CLK;

    // Frame buffer: pixel value is addr[0]^addr[9], returned one CLK after the address.
    function automatic logic fb_bit(input logic [16:0] a);
        return a[0] ^ a[9];
    endfunction

    initial begin
        bus_a.VGA_DATA = 1'b0;
        bus_b.VGA_DATA = 1'b0;
    end

    always @(posedge CLK) begin
        bus_a.VGA_DATA <= fb_bit(bus_a.VGA_ADDR);
        bus_b.VGA_DATA <= fb_bit(bus_b.VGA_ADDR);
    end

    always @(posedge CLK) if (bus_a.FRAME_START) fs_cnt_a <= fs_cnt_a + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
        end
    endtask

    // Inst A: cycle 2*p after its FRAME_START tick is the negedge just after pixel p's tick.
    task automatic goto(input int p);
        while (cyc < 2 * p) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic first_tick(input string tag);
        int fa, fb;
        fa = 0;
        fb = 0;
        RESET = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            if (bus_a.FRAME_START && fa == 0) fa = i;
            if (bus_b.FRAME_START && fb == 0) fb = i;
        end
        chk({tag, "_a_first_tick"}, fa, 2);
        chk({tag, "_b_first_tick"}, fb, 4);
        cyc = 4;
    endtask

    task automatic run_a();
        int base;
        goto(96);   chk("a_hs_low_96", bus_a.VGA_HS, 0); chk("a_vs_low", bus_a.VGA_VS, 0);
        base = fs_cnt_a;
        goto(97);   chk("a_hs_high_97", bus_a.VGA_HS, 1);
        goto(800);  chk("a_hs_high_799", bus_a.VGA_HS, 1);
        goto(801);  chk("a_hs_low_line1", bus_a.VGA_HS, 0);
        goto(1600); chk("a_vs_low_end", bus_a.VGA_VS, 0);
        goto(1601); chk("a_vs_rise", bus_a.VGA_VS, 1);
        goto(4143); chk("a_addr_h143", bus_a.VGA_ADDR, 0);
        goto(4144); chk("a_addr_h144", bus_a.VGA_ADDR, 0); chk("a_col_blank", bus_a.VGA_COLOUR, 8'h00);
        goto(4145); chk("a_col_bg", bus_a.VGA_COLOUR, 8'h03); chk("a_addr_h145", bus_a.VGA_ADDR, 0);
        goto(4146); chk("a_addr_h146", bus_a.VGA_ADDR, 1);
        goto(4147); chk("a_col_fg", bus_a.VGA_COLOUR, 8'hE0);
        goto(4783); chk("a_addr_h783", bus_a.VGA_ADDR, 319);
        goto(4784); chk("a_addr_h784", bus_a.VGA_ADDR, 0); chk("a_col_lastx", bus_a.VGA_COLOUR, 8'hE0);
        goto(4785); chk("a_col_hblank", bus_a.VGA_COLOUR, 8'h00);
        bus_a.CONFIG_COLOURS = 16'h5AA5;
        goto(5748); chk("a_addr_y2", bus_a.VGA_ADDR, 514); chk("a_col_old_bg", bus_a.VGA_COLOUR, 8'h03);
        goto(5749); chk("a_col_old_fg", bus_a.VGA_COLOUR, 8'hE0);
        goto(7183); chk("a_addr_last", bus_a.VGA_ADDR, {8'd1, 9'd319});
        goto(7184); chk("a_col_last", bus_a.VGA_COLOUR, 8'h03); chk("a_addr_vblank", bus_a.VGA_ADDR, 0);
        goto(7999); chk("a_fs_before", bus_a.FRAME_START, 0);
        goto(8000); chk("a_fs_pulse", bus_a.FRAME_START, 1);
        @(negedge CLK);
        chk("a_fs_one_clk", bus_a.FRAME_START, 0);
        chk("a_fs_once", fs_cnt_a, base + 1);
        cyc = 1;
        goto(4146); chk("a_col_new_bg", bus_a.VGA_COLOUR, 8'hA5);
        goto(4147); chk("a_col_new_fg", bus_a.VGA_COLOUR, 8'h5A);
    endtask

    task automatic run_b();
        int n;
        n = 0;
        while (bus_b.VGA_HS !== 1'b0 && n < 5000) begin @(negedge CLK); n++; end
        chk("b_hs_fall_seen", bus_b.VGA_HS, 0);
        n = 0;
        while (bus_b.VGA_HS === 1'b0 && n < 5000) begin @(negedge CLK); n++; end
        chk("b_hs_low_clk", n, 384);
        n = 0;
        while (bus_b.VGA_HS === 1'b1 && n < 5000) begin @(negedge CLK); n++; end
        chk("b_hs_high_clk", n, 2816);
        n = 0;
        while (bus_b.VGA_VS !== 1'b1 && n < 40000) begin @(negedge CLK); n++; end
        n = 0;
        while (bus_b.VGA_VS !== 1'b0 && n < 40000) begin @(negedge CLK); n++; end
        chk("b_vs_fall_seen", bus_b.VGA_VS, 0);
        n = 0;
        while (bus_b.VGA_VS === 1'b0 && n < 40000) begin @(negedge CLK); n++; end
        chk("b_vs_low_clk", n, 6400);
        n = 0;
        while (bus_b.VGA_VS === 1'b1 && n < 40000) begin @(negedge CLK); n++; end
        chk("b_vs_high_clk", n, 25600);
    endtask

    initial begin
        RESET = 1'b1;
        bus_a.CONFIG_COLOURS = 16'hE003;
        bus_b.CONFIG_COLOURS = 16'hE003;
        repeat (2) @(negedge CLK);
        chk("rst_addr", bus_a.VGA_ADDR, 0);
        chk("rst_hs", bus_a.VGA_HS, 1);
        chk("rst_vs", bus_a.VGA_VS, 1);
        chk("rst_col", bus_a.VGA_COLOUR, 0);
        chk("rst_fs", bus_a.FRAME_START, 0);
        chk("rst_b_hs", bus_b.VGA_HS, 1);
        first_tick("rel1");

        goto(4300);
        chk("pre_rst_addr", bus_a.VGA_ADDR, 78);
        chk("pre_rst_col", bus_a.VGA_COLOUR, 8'hE0);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_addr", bus_a.VGA_ADDR, 0);
        chk("mid_rst_col", bus_a.VGA_COLOUR, 0);
        chk("mid_rst_hs", bus_a.VGA_HS, 1);
        chk("mid_rst_vs", bus_a.VGA_VS, 1);
        repeat (3) @(negedge CLK);
        first_tick("rel2");

        fork
            run_a();
            run_b();
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
